// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: round-robin CPU/loader arbitration,
// sub-word load extraction and read-modify-write for sub-word stores.
module dmem_access_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter bit RR_INIT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_uns,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic [31:0] RA,
  output logic [31:0] WA,
  output logic [31:0] Di,
  input  logic [31:0] Do,
  output logic        MemWr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 own_q, own_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          word_q, word_d;
  logic                 err_q, err_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;
  logic [31:0]          ld_rdata_q, ld_rdata_d;

  logic        cpu_pick, ld_pick;
  logic        sel_we, sel_uns, sel_err;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic [31:0] mem_addr, shifted, load_val, merged;

  // last_q=1 means the loader won last, so the CPU takes a tie
  assign cpu_pick = cpu_req && (!ld_req || last_q);
  assign ld_pick  = ld_req && !cpu_pick;

  always_comb begin
    sel_we    = ld_pick ? ld_we    : cpu_we;
    sel_addr  = ld_pick ? ld_addr  : cpu_addr;
    sel_size  = ld_pick ? 2'b10    : cpu_size;
    sel_uns   = ld_pick ? 1'b0     : cpu_uns;
    sel_wdata = ld_pick ? ld_wdata : cpu_wdata;
    sel_err   = (sel_size == 2'b11)
             || ((sel_addr >> ADDR_BITS) != 32'd0)
             || (sel_size == 2'b01 && sel_addr[0])
             || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    mem_addr = '0;
    mem_addr[ADDR_BITS-1:2] = addr_q[ADDR_BITS-1:2];
  end

  always_comb begin
    shifted = Do >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = Do;
    endcase
  end

  always_comb begin
    merged = word_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_pick || ld_pick) begin
          own_d   = ld_pick;
          last_d  = ld_pick;
          we_d    = sel_we;
          addr_d  = sel_addr[ADDR_BITS-1:0];
          size_d  = sel_size;
          uns_d   = sel_uns;
          wdata_d = sel_wdata;
          err_d   = sel_err;
          if (sel_err)
            state_d = RESP;
          else if (sel_we && sel_size == 2'b10)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        word_d = Do;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
          if (own_q) ld_rdata_d  = load_val;
          else       cpu_rdata_d = load_val;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= RR_INIT;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign cpu_gnt   = !rst && state_q == IDLE && cpu_pick;
  assign ld_gnt    = !rst && state_q == IDLE && ld_pick;
  assign cpu_done  = state_q == RESP && !own_q;
  assign ld_done   = state_q == RESP && own_q;
  assign cpu_err   = cpu_done && err_q;
  assign ld_err    = ld_done && err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign RA        = (state_q != IDLE) ? mem_addr : 32'd0;
  assign WA        = RA;
  assign MemWr     = state_q == WRITE;
  assign Di        = MemWr ? merged : 32'd0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 256-byte
// behavioural memory attached to RA/WA/Di/Do/MemWr.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, cpu_uns = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [1:0]  cpu_size = 0;
  logic        cpu_gnt, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        ld_req = 0, ld_we = 0;
  logic [31:0] ld_addr = 0, ld_wdata = 0;
  logic        ld_gnt, ld_done, ld_err;
  logic [31:0] ld_rdata;
  logic [31:0] RA, WA, Di, Do;
  logic        MemWr;

  logic [7:0]  mem [256];
  int          wr_cnt = 0;
  int          nchk = 0, nfail = 0;
  int          r_lat, r_nwr, w0, n;
  logic [31:0] r_wa, r_di, r_rd;
  logic        r_err;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_size(cpu_size), .cpu_uns(cpu_uns), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_done(ld_done),
    .ld_rdata(ld_rdata), .ld_err(ld_err),
    .RA(RA), .WA(WA), .Di(Di), .Do(Do), .MemWr(MemWr)
  );

  assign Do = {mem[RA[7:0] + 8'd3], mem[RA[7:0] + 8'd2],
               mem[RA[7:0] + 8'd1], mem[RA[7:0]]};

  always @(posedge clk) begin
    if (MemWr) begin
      mem[WA[7:0]]         <= Di[7:0];
      mem[WA[7:0] + 8'd1]  <= Di[15:8];
      mem[WA[7:0] + 8'd2]  <= Di[23:16];
      mem[WA[7:0] + 8'd3]  <= Di[31:24];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] wd);
    int g;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = a;
    cpu_size = sz; cpu_uns = u; cpu_wdata = wd;
    #1 g = 0;
    while (!cpu_gnt && g < 20) begin
      @(negedge clk); #1 g++;
    end
    chk("cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(posedge clk);
    #1 cpu_req = 0; cpu_we = ~we; cpu_addr = 32'hFFFF_FFFF;
    cpu_size = 2'b11; cpu_uns = ~u; cpu_wdata = ~wd;
    r_lat = 0; r_nwr = 0; r_wa = '0; r_di = '0;
    do begin
      @(negedge clk); r_lat++;
      if (MemWr) begin r_nwr++; r_wa = WA; r_di = Di; end
    end while (!cpu_done && r_lat < 20);
    r_err = cpu_err; r_rd = cpu_rdata;
  endtask

  task automatic ld_op(input logic we, input logic [31:0] a,
                       input logic [31:0] wd);
    int g;
    @(negedge clk);
    ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = wd;
    #1 g = 0;
    while (!ld_gnt && g < 20) begin
      @(negedge clk); #1 g++;
    end
    chk("ld_gnt", {31'd0, ld_gnt}, 32'd1);
    @(posedge clk);
    #1 ld_req = 0; ld_we = ~we; ld_addr = 32'hFFFF_FFFF; ld_wdata = ~wd;
    r_lat = 0; r_nwr = 0; r_wa = '0; r_di = '0;
    do begin
      @(negedge clk); r_lat++;
      if (MemWr) begin r_nwr++; r_wa = WA; r_di = Di; end
    end while (!ld_done && r_lat < 20);
    r_err = ld_err; r_rd = ld_rdata;
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_ra", RA, 0);
    chk("rst_di", Di, 0);
    chk("rst_memwr", {31'd0, MemWr}, 0);
    chk("rst_done", {30'd0, cpu_done, ld_done}, 0);
    chk("rst_rdata", cpu_rdata | ld_rdata, 0);
    @(negedge clk); rst = 0;

    ld_op(1, 32'h40, 32'h8899AABB);
    chk("ld_sw_lat", r_lat, 2);
    chk("ld_sw_nwr", r_nwr, 1);
    ld_op(1, 32'h44, 32'h01020304);
    chk("ld_sw2_di", r_di, 32'h01020304);

    cpu_op(0, 32'h41, 2'b00, 0, 0);
    chk("lb_lat", r_lat, 2);
    chk("lb_rd", r_rd, 32'hFFFFFFAA);
    chk("lb_err", {31'd0, r_err}, 0);
    chk("lb_nwr", r_nwr, 0);
    cpu_op(0, 32'h41, 2'b00, 1, 0);
    chk("lbu_rd", r_rd, 32'h000000AA);

    cpu_op(1, 32'h42, 2'b00, 0, 32'h11);
    chk("sb_lat", r_lat, 3);
    chk("sb_nwr", r_nwr, 1);
    chk("sb_wa", r_wa, 32'h40);
    chk("sb_di", r_di, 32'h8811AABB);

    cpu_op(0, 32'h42, 2'b01, 0, 0);
    chk("lh_rd", r_rd, 32'hFFFF8811);

    cpu_op(1, 32'hFC, 2'b10, 0, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 2);
    chk("sw_nwr", r_nwr, 1);
    chk("sw_wa", r_wa, 32'hFC);
    chk("sw_di", r_di, 32'hDEADBEEF);
    cpu_op(0, 32'hFC, 2'b10, 0, 0);
    chk("lw_rd", r_rd, 32'hDEADBEEF);

    cpu_op(1, 32'h43, 2'b01, 0, 32'h5555);
    chk("sh_mis_lat", r_lat, 1);
    chk("sh_mis_err", {31'd0, r_err}, 1);
    chk("sh_mis_nwr", r_nwr, 0);
    chk("sh_mis_rd", r_rd, 32'hDEADBEEF);
    cpu_op(0, 32'h100, 2'b10, 0, 0);
    chk("lw_oor_lat", r_lat, 1);
    chk("lw_oor_err", {31'd0, r_err}, 1);
    chk("lw_oor_rd", r_rd, 32'hDEADBEEF);
    cpu_op(0, 32'h40, 2'b11, 0, 0);
    chk("size11_err", {31'd0, r_err}, 1);
    ld_op(0, 32'h42, 0);
    chk("ld_mis_lat", r_lat, 1);
    chk("ld_mis_err", {31'd0, r_err}, 1);

    // reset while the SB sits in READ
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44;
    cpu_size = 2'b00; cpu_uns = 0; cpu_wdata = 32'hFF;
    #1 chk("rmw_gnt", {31'd0, cpu_gnt}, 1);
    @(posedge clk); #1 cpu_req = 0;
    w0 = wr_cnt;
    @(negedge clk);
    chk("rmw_read_ra", RA, 32'h44);
    rst = 1;
    #1;
    chk("mid_rst_ra", RA, 0);
    chk("mid_rst_wa", WA, 0);
    chk("mid_rst_di", Di, 0);
    chk("mid_rst_memwr", {31'd0, MemWr}, 0);
    chk("mid_rst_rdata", cpu_rdata | ld_rdata, 0);
    chk("mid_rst_done", {30'd0, cpu_done, ld_done}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_nowrite", wr_cnt, w0);

    // tie right after reset: CPU first, loader next
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    cpu_size = 2'b10; cpu_uns = 0;
    ld_req = 1; ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'h12345678;
    #1;
    chk("tie1_cpu_gnt", {31'd0, cpu_gnt}, 1);
    chk("tie1_ld_gnt", {31'd0, ld_gnt}, 0);
    @(posedge clk); #1 cpu_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_done && n < 20);
    chk("tie1_cpu_lat", n, 2);
    chk("tie1_cpu_rd", cpu_rdata, 32'h8811AABB);
    chk("tie1_ld_wait", {31'd0, ld_gnt}, 0);
    @(negedge clk); #1;
    chk("tie1_ld_gnt_next", {31'd0, ld_gnt}, 1);
    @(posedge clk); #1 ld_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld_done && n < 20);
    chk("tie1_ld_lat", n, 2);

    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    cpu_size = 2'b00; cpu_uns = 1;
    ld_req = 1; ld_we = 0; ld_addr = 32'h80;
    #1;
    chk("tie2_cpu_gnt", {31'd0, cpu_gnt}, 1);
    chk("tie2_ld_gnt", {31'd0, ld_gnt}, 0);
    @(posedge clk); #1 cpu_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_done && n < 20);
    chk("tie2_cpu_rd", cpu_rdata, 32'h00000078);
    @(negedge clk); #1;
    chk("tie2_ld_gnt_next", {31'd0, ld_gnt}, 1);
    @(posedge clk); #1 ld_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld_done && n < 20);
    chk("tie2_ld_rd", ld_rdata, 32'h12345678);
    chk("tie2_ld_err", {31'd0, ld_err}, 0);

    cpu_op(0, 32'h44, 2'b10, 0, 0);
    chk("post_rst_lw", r_rd, 32'h01020304);
    chk("post_rst_lat", r_lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencing controller in front of the 256-byte data memory (byte array, little-endian word port, combinational read, word-wide write on MemWr). It shares the memory between the pipeline MEM stage (CPU port) and a debug/loader port using round-robin arbitration. It converts byte/halfword/word loads and stores into aligned word accesses, and performs read-modify-write for sub-word stores. The CPU port stalls on cpu_done.

Parameters:
ADDR_BITS, 8, byte-address bits implemented by the memory; any higher address bit set is an error
RR_INIT, 1, reset value of last_grant (1 = loader), so the CPU wins the first tie

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cpu_req  in  1  CPU access request, sampled only in IDLE
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_uns  in  1  load zero-extend (1) or sign-extend (0)
cpu_wdata  in  32  store data, right-aligned
cpu_gnt  out  1  one-cycle pulse: request accepted
cpu_done  out  1  one-cycle pulse: access complete
cpu_rdata  out  32  load result, valid with cpu_done, held until next done
cpu_err  out  1  with cpu_done: misaligned, out-of-range or illegal size
ld_req  in  1  loader word request
ld_we  in  1  loader store/load
ld_addr  in  32  loader byte address
ld_wdata  in  32  loader store data
ld_gnt  out  1  one-cycle accept pulse
ld_done  out  1  one-cycle completion pulse
ld_rdata  out  32  loader load result
ld_err  out  1  with ld_done: misaligned or out-of-range
RA  out  32  memory read address
WA  out  32  memory write address
Di  out  32  memory write data
Do  in  32  memory read data (combinational)
MemWr  out  1  memory write enable

Behaviour:
- Reset: state=IDLE, last_grant=RR_INIT. All outputs 0, including RA, WA, Di, MemWr and the rdata registers. Reset takes effect immediately, mid-operation included. An RMW interrupted before WRITE never writes.
- Latched request (owner, we, addr, size, uns, wdata) is captured on the accept edge. The requester may change its inputs after the gnt pulse.
- Arbitration happens in IDLE only:
  - one request pending: grant it;
  - both pending: grant the port not in last_grant, then update last_grant.
  - gnt pulses in the same cycle as the accept edge (IDLE, combinational from the request).
- Error check at accept, in this order:
  - size==11;
  - any address bit at or above ADDR_BITS set;
  - half with addr[0]=1;
  - word with addr[1:0]!=0.
  - Error path: IDLE→RESP, err=1, MemWr never asserted, rdata unchanged.
- State sequences:
  - load: IDLE→READ→RESP;
  - word store: IDLE→WRITE→RESP;
  - byte/half store: IDLE→READ→WRITE→RESP.
- Latency from accept edge T: error done at T+1; load and word store done at T+2; sub-word store done at T+3.
- RA = WA = latched address with [1:0] cleared and [31:ADDR_BITS] zero, driven in all non-IDLE states.
- READ: captures Do into a word register.
  - Load: byte/half selected by addr[1:0] (half uses addr[1]), then sign- or zero-extended. Result lands in the owner's rdata.
- WRITE: MemWr=1 for exactly that one cycle, asserted in no other state.
  - Di = wdata (word store), or the captured word with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0].
- RESP: owner's done=1 for one cycle, err as computed, then IDLE. A new request can be accepted in the cycle after RESP.
- Loader port is word-only; its size is forced to 10.
- Requests arriving while busy wait and are never dropped. The requester holds req until gnt.

Test Plan:
- Memory word 0x40 = 0x8899AABB; CPU LB addr 0x41, uns=0 → cpu_done at T+2, cpu_rdata=0xFFFFFFAA; repeat with uns=1 → 0x000000AA.
- CPU SB addr 0x42, wdata=0x11 over 0x8899AABB → READ then one MemWr cycle, WA=0x40, Di=0x8811AABB, cpu_done at T+3.
- CPU SW addr 0xFC, wdata=0xDEADBEEF → MemWr one cycle, WA=0xFC, done at T+2; LW 0xFC returns 0xDEADBEEF.
- cpu_req and ld_req asserted together after reset → CPU granted first, loader next (ld_gnt the cycle after cpu_done). On the next tie the CPU wins again, since last_grant=loader.
- SH addr 0x43 and LW addr 0x100 → done at T+1 with err=1, MemWr stays 0, rdata unchanged.
- Assert rst while in READ of SB → MemWr never pulses, memory unchanged, all outputs 0, a subsequent request is accepted normally.
